regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//  Control end of the 16x8 register file: fetches 16-bit instructions over a req/valid
//  instruction-memory handshake, decodes them and drives the register-file ports.
//  Read selects: sba, sbb. Write select: srd. Write strobe: le. Write data: di.
//  Consumes out_a/out_b to compute results with an 8-bit ALU.
//  Sits between instruction memory and the register file in the single-clock processor.
// PARAMETERS
//  PC_W   8   program-counter / imem address width
// PORTS
//  clk         in   1     system clock, all state updates on posedge
//  rst         in   1     synchronous, active-high reset
//  imem_req    out  1     fetch request, held high until imem_valid sampled
//  imem_addr   out  PC_W  fetch address (= pc while imem_req high)
//  imem_valid  in   1     imem_data valid this cycle; ignored when imem_req low
//  imem_data   in   16    instruction word
//  sba         out  4     register-file read select A
//  sbb         out  4     register-file read select B
//  out_a       in   8     register-file read data A (combinational from sba)
//  out_b       in   8     register-file read data B (combinational from sbb)
//  srd         out  4     register-file write select
//  le          out  1     register-file write strobe (registered)
//  di          out  8     register-file write data (registered)
//  pc          out  PC_W  current program counter
//  halted      out  1     high in HALT state
// BEHAVIOUR
//  Reset: state=FETCH, pc=0, ir=0, z=0, imem_req=0, le=0, srd=0, di=0, sba=sbb=0, halted=0.
//  Instr: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb; imm8 = {ra,rb}.
//  Opcodes:
//   0 NOP; 1 LDI rd<=imm8; 2 MOV rd<=ra; 3 ADD; 4 SUB; 5 AND; 6 OR; 7 XOR (rd<=ra op rb).
//   8 JMP pc<=imm8; 9 JZ if z pc<=imm8; F HALT; A-E behave as NOP.
//  FSM states: FETCH -> EXEC -> (WB1 -> WB2 ->) FETCH.
//  FETCH: imem_req=1, imem_addr=pc. On an edge with imem_valid=1: ir<=imem_data,
//   pc<=pc+1 (wraps 255->0), go EXEC. Zero-wait imem therefore costs exactly 1 cycle.
//  EXEC: sba=ir.ra, sbb=ir.rb combinationally.
//   ALU ops / MOV / LDI: di<=result, srd<=rd, le<=1, go WB1.
//   JMP/JZ/NOP: no write, go FETCH. HALT: go HALT.
//  WB1: le=1 visible; the register file latches srd/le at end of WB1. At the edge: le<=0.
//  WB2: le=0, di and srd held stable; the register file captures di at end of WB2.
//   Then FETCH. Write latency: EXEC edge + 2 cycles; a following instruction reads the new value.
//  Arithmetic: 8-bit two's-complement wrap, carry/borrow discarded. SUB = ra - rb.
//  z <= (result==0) on ALU ops 3-7 only; LDI/MOV/jumps leave z unchanged.
//  JMP/JZ target overrides the already-incremented pc.
//  rd=10 (PIN) and rd=14 (Xh) load from In/Xh inside the register file, not from di;
//   the sequencer still issues the write unchanged.
//  HALT: halted=1, imem_req=0, le=0; exits only via rst.
//  rst in any state, including mid-fetch or WB1/WB2, returns all state to reset values at
//   that edge; a WB1-pending write is abandoned (le=0 next cycle).
//  imem_valid while imem_req=0 is ignored; imem_data is sampled only on the accepting edge.
// STRUCTURE
//  regfile_seq_pkg: op_e opcode enum, state_e FSM enum, instr_t packed struct
//   {op,rd,ra,rb}, constant REG_PIN=10, REG_XH=14.
//  Sub-module regfile_seq_alu: combinational (op, a, b, imm8) -> (result, zero).
//  Top holds the FSM, pc, ir, z and the output registers.
// TESTING
//  rst, imem zero-wait: LDI r1,0x05; LDI r2,0x03; ADD r3,r1,r2 -> third write: srd=3, di=0x08.
//   le high exactly 1 cycle per write.
//  SUB r4,r2,r2 -> di=0x00, z=1; following JZ 0x20 -> next imem_addr=0x20.
//  Wrap: LDI r1,0xFF; LDI r2,0x01; ADD r0,r1,r2 -> di=0x00, z=1.
//   pc run past 0xFF fetches address 0x00.
//  imem_valid delayed 3 cycles -> imem_req/imem_addr held constant.
//   ir unchanged until the accepting edge. Stray imem_valid while imem_req=0 is ignored.
//  rst asserted in WB1 -> le=0 and pc=0 next cycle; the targeted register keeps its old value.
//  HALT -> halted=1, imem_req stays 0 for 20 cycles; rst -> fetch resumes at 0x00.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file sequencer.
// Instruction layout: [15:12] op, [11:8] rd, [7:4] ra, [3:0] rb.
package regfile_seq_pkg;

  localparam int unsigned PC_W_DEF  = 8;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned REG_SEL_W = 4;
  localparam int unsigned OP_W      = 4;

  // Registers loaded from outside sources by the register file itself
  localparam logic [REG_SEL_W-1:0] REG_PIN = REG_SEL_W'(10);
  localparam logic [REG_SEL_W-1:0] REG_XH  = REG_SEL_W'(14);

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_HALT = 4'hF
  } op_e;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_WB1   = 3'd2,
    ST_WB2   = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [REG_SEL_W-1:0] rd;
    logic [REG_SEL_W-1:0] ra;
    logic [REG_SEL_W-1:0] rb;
  } instr_t;

  // Opcodes that produce a register-file write
  function automatic logic op_writes(input op_e op);
    case (op)
      OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  // Only true ALU operations update the zero flag
  function automatic logic op_sets_z(input op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_seq_if.sv
// Instruction-memory handshake plus register-file port bundle.
// master = sequencer side, slave = memory / register-file side.
interface regfile_seq_if
  import regfile_seq_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
);

  logic                 imem_req;
  logic [PC_W-1:0]      imem_addr;
  logic                 imem_valid;
  logic [INSTR_W-1:0]   imem_data;
  logic [REG_SEL_W-1:0] sba;
  logic [REG_SEL_W-1:0] sbb;
  logic [DATA_W-1:0]    out_a;
  logic [DATA_W-1:0]    out_b;
  logic [REG_SEL_W-1:0] srd;
  logic                 le;
  logic [DATA_W-1:0]    di;

  modport master (
    output imem_req, imem_addr, sba, sbb, srd, le, di,
    input  imem_valid, imem_data, out_a, out_b
  );

  modport slave (
    input  imem_req, imem_addr, sba, sbb, srd, le, di,
    output imem_valid, imem_data, out_a, out_b
  );

endinterface

// File: rtl/regfile_seq_alu.sv
// Combinational 8-bit ALU for the sequencer: result plus zero detect.
// Arithmetic wraps modulo 256; carry/borrow are discarded.
module regfile_seq_alu
  import regfile_seq_pkg::*;
(
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm8,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (op)
      OP_LDI:  result = imm8;
      OP_MOV:  result = a;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Fetch/decode/write-back sequencer driving the 16x8 register file.
// FETCH -> EXEC -> (WB1 -> WB2 ->) FETCH; HALT is left only through rst.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
)(
  input  logic            clk,
  input  logic            rst,
  regfile_seq_if.master   bus,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  instr_t               ir_q, ir_d;
  logic                 z_q, z_d;
  logic                 req_q, req_d;
  logic                 le_q, le_d;
  logic                 halted_q, halted_d;
  logic [REG_SEL_W-1:0] srd_q, srd_d;
  logic [DATA_W-1:0]    di_q, di_d;

  logic [DATA_W-1:0]    imm8;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_zero;

  assign imm8 = {ir_q.ra, ir_q.rb};

  regfile_seq_alu u_alu (
    .op     (ir_q.op),
    .a      (bus.out_a),
    .b      (bus.out_b),
    .imm8   (imm8),
    .result (alu_result),
    .zero   (alu_zero)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_d      = z_q;
    le_d     = le_q;
    srd_d    = srd_q;
    di_d     = di_q;

    case (state_q)
      ST_FETCH: begin
        // Only a request we are actually driving can be answered
        if (req_q && bus.imem_valid) begin
          ir_d    = instr_t'(bus.imem_data);
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_writes(ir_q.op)) begin
          di_d    = alu_result;
          srd_d   = ir_q.rd;
          le_d    = 1'b1;
          state_d = ST_WB1;
          if (op_sets_z(ir_q.op)) begin
            z_d = alu_zero;
          end
        end else begin
          case (ir_q.op)
            OP_JMP:  pc_d = PC_W'(imm8);
            OP_JZ:   if (z_q) pc_d = PC_W'(imm8);
            default: ;
          endcase
          state_d = (ir_q.op == OP_HALT) ? ST_HALT : ST_FETCH;
        end
      end
      ST_WB1: begin
        le_d    = 1'b0;
        state_d = ST_WB2;
      end
      ST_WB2: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    req_d    = (state_d == ST_FETCH);
    halted_d = (state_d == ST_HALT);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      z_q      <= 1'b0;
      req_q    <= 1'b0;
      le_q     <= 1'b0;
      halted_q <= 1'b0;
      srd_q    <= '0;
      di_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      req_q    <= req_d;
      le_q     <= le_d;
      halted_q <= halted_d;
      srd_q    <= srd_d;
      di_q     <= di_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.sba       = ir_q.ra;
  assign bus.sbb       = ir_q.rb;
  assign bus.srd       = srd_q;
  assign bus.le        = le_q;
  assign bus.di        = di_q;
  assign pc            = pc_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: instruction memory with programmable
// wait states, a two-phase register-file model, and fetch/write logs.
module tb_regfile_sequencer;

  logic       clk;
  logic       rst;
  logic [7:0] pc;
  logic       halted;

  regfile_seq_if #(.PC_W(8)) bus ();

  regfile_sequencer #(.PC_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .pc     (pc),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory with wait states and a stray-valid injector
  logic [15:0] mem [256];
  int          delay_cfg = 0;
  int          wait_cnt  = 0;
  logic        stray     = 1'b0;

  assign bus.imem_data  = mem[bus.imem_addr];
  assign bus.imem_valid = (bus.imem_req && (wait_cnt >= delay_cfg)) || stray;

  always @(posedge clk) begin
    if (rst)                                wait_cnt <= 0;
    else if (bus.imem_req && bus.imem_valid) wait_cnt <= 0;
    else if (bus.imem_req)                  wait_cnt <= wait_cnt + 1;
  end

  // Register file: select/strobe latched at end of WB1, data captured at end of WB2
  logic [7:0] regs [16];
  logic       pend = 1'b0;
  logic [3:0] pend_sel = '0;

  assign bus.out_a = regs[bus.sba];
  assign bus.out_b = regs[bus.sbb];

  always @(posedge clk) begin
    pend     <= bus.le && !rst;
    pend_sel <= bus.srd;
    if (pend && !rst) regs[pend_sel] <= bus.di;
  end

  // Logs of accepted fetch addresses and issued writes {srd, di}
  logic [7:0]  fetch_q [$];
  logic [11:0] wr_q    [$];
  int          le_viol = 0;
  logic        le_prev = 1'b0;
  logic [11:0] wr_prev = '0;

  always @(posedge clk) begin
    if (!rst && bus.imem_req && bus.imem_valid) fetch_q.push_back(bus.imem_addr);
    if (!rst && bus.le) wr_q.push_back({bus.srd, bus.di});
    // le must be a single-cycle pulse and srd/di must hold through WB2
    if (!rst && bus.le && le_prev) le_viol++;
    if (!rst && le_prev && ({bus.srd, bus.di} != wr_prev)) le_viol++;
    le_prev <= bus.le && !rst;
    wr_prev <= {bus.srd, bus.di};
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    fetch_q.delete();
    wr_q.delete();
    rst = 1'b0;
  endtask

  task automatic wait_fetches(input int n, input string tag);
    int c = 0;
    while (fetch_q.size() < n && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(fetch_q.size() >= n), 32'd1);
  endtask

  task automatic wait_halt(input string tag);
    int c = 0;
    while (!halted && c < 400) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(halted), 32'd1);
  endtask

  localparam logic [7:0]  EXP_FA [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h20, 8'h21,
                                          8'h24, 8'h25, 8'h26, 8'h40, 8'hFE, 8'hFF, 8'h00};
  localparam logic [11:0] EXP_WA [7]  = '{12'h105, 12'h203, 12'h308, 12'h400,
                                          12'h1FF, 12'h201, 12'h000};
  localparam logic [11:0] EXP_WB [7]  = '{12'h1C3, 12'h25A, 12'h342, 12'h4DB,
                                          12'h599, 12'h6C3, 12'h797};

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 16; i++) regs[i] = 8'h00;
    clear_mem();

    // Program A: LDI/ADD/SUB, JZ taken, LDI preserves z, wrap-around ADD, JMP, pc wrap
    mem[8'h00] = 16'h1105;  mem[8'h01] = 16'h1203;  mem[8'h02] = 16'h3312;
    mem[8'h03] = 16'h4422;  mem[8'h04] = 16'h9020;
    mem[8'h20] = 16'h11FF;  mem[8'h21] = 16'h9024;
    mem[8'h24] = 16'h1201;  mem[8'h25] = 16'h3012;  mem[8'h26] = 16'h9040;
    mem[8'h40] = 16'h80FE;
    do_reset();
    wait_fetches(14, "A_fetch_count");
    for (int i = 0; i < 14; i++)
      chk($sformatf("A_fetch%0d", i), (i < fetch_q.size()) ? 32'(fetch_q[i]) : 32'hFFFF, 32'(EXP_FA[i]));
    for (int i = 0; i < 7; i++)
      chk($sformatf("A_write%0d", i), (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF, 32'(EXP_WA[i]));
    chk("A_r3_value", 32'(regs[3]), 32'h08);

    // Program B: logic ops, MOV, negative SUB, JZ not taken, HALT
    clear_mem();
    mem[0] = 16'h11C3;  mem[1] = 16'h125A;  mem[2] = 16'h5312;
    mem[3] = 16'h6412;  mem[4] = 16'h7512;  mem[5] = 16'h2610;
    mem[6] = 16'h4721;  mem[7] = 16'h9030;  mem[8] = 16'hF000;
    do_reset();
    wait_halt("B_halt");
    for (int i = 0; i < 9; i++)
      chk($sformatf("B_fetch%0d", i), (i < fetch_q.size()) ? 32'(fetch_q[i]) : 32'hFFFF, i);
    for (int i = 0; i < 7; i++)
      chk($sformatf("B_write%0d", i), (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF, 32'(EXP_WB[i]));
    chk("le_pulse_and_hold", le_viol, 0);

    // Reset from a non-reset state (halted, srd=7, di=0x97)
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_le", 32'(bus.le), 0);
    chk("rst_srd", 32'(bus.srd), 0);
    chk("rst_di", 32'(bus.di), 0);
    chk("rst_sba_sbb", 32'({bus.sba, bus.sbb}), 0);
    chk("rst_halted", 32'(halted), 0);

    // Delayed imem_valid, with a stray valid while imem_req is low
    clear_mem();
    mem[0] = 16'h15A5;
    delay_cfg = 3;
    do_reset();
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stray = 1'b0;
      chk($sformatf("D_req%0d", i), 32'(bus.imem_req), 1);
      chk($sformatf("D_addr%0d", i), 32'(bus.imem_addr), 0);
      chk($sformatf("D_ir_held%0d", i), 32'(bus.sba), 0);
    end
    wait_fetches(1, "D_accept");
    @(negedge clk);
    chk("D_sba_after_accept", 32'(bus.sba), 32'hA);
    chk("D_pc_after_accept", 32'(pc), 1);
    repeat (3) @(negedge clk);
    chk("D_write", (wr_q.size() > 0) ? 32'(wr_q[0]) : 32'hFFFF, 32'h5A5);
    delay_cfg = 0;

    // Reset during WB1 abandons the pending write
    @(negedge clk);
    rst = 1'b1;
    clear_mem();
    mem[0] = 16'h1677;
    regs[6] = 8'h11;
    do_reset();
    begin
      int c = 0;
      while (!bus.le && c < 50) begin
        @(negedge clk);
        c++;
      end
      chk("W_reach_wb1", 32'(bus.le), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("W_le_after_rst", 32'(bus.le), 0);
    chk("W_pc_after_rst", 32'(pc), 0);
    repeat (3) @(negedge clk);
    chk("W_r6_kept", 32'(regs[6]), 32'h11);

    // HALT: request stays low, stray valid ignored, rst restarts at 0
    clear_mem();
    mem[0] = 16'hF000;
    do_reset();
    wait_halt("H_halt");
    begin
      int req_hi = 0;
      for (int i = 0; i < 20; i++) begin
        stray = (i == 5);
        @(negedge clk);
        if (bus.imem_req) req_hi++;
      end
      stray = 1'b0;
      chk("H_req_low20", req_hi, 0);
    end
    chk("H_still_halted", 32'(halted), 1);
    chk("H_pc", 32'(pc), 1);
    chk("H_single_fetch", fetch_q.size(), 1);
    do_reset();
    wait_fetches(1, "H_restart");
    chk("H_restart_addr", (fetch_q.size() > 0) ? 32'(fetch_q[0]) : 32'hFFFF, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
